// File: rtl/spi_pkg.sv
//-----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master frame engine and the slave-side FSM.
// Both sides build and decode the same 16-bit frame:
//   {addr[6:0], rw, data[7:0]}, MSB first.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default field widths
//   FRAME_BITS              : bits per frame at the default widths
//   RW_READ                 : value of the rw bit that marks a read
//   state_t                 : frame engine states
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_pkg;

  localparam int   ADDR_W_DEF = 7;
  localparam int   DATA_W_DEF = 8;
  localparam int   FRAME_BITS = ADDR_W_DEF + 1 + DATA_W_DEF;
  localparam logic RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GUARD = 3'd1,
    ST_SETUP = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
//-----------------------------------------------------------------------------
// spi_master_if
// Host-side request/response bus of the SPI master.
//   start  : one-cycle request pulse
//   rw     : 1 = read, 0 = write (captured with start)
//   addr   : target address      (captured with start)
//   wdata  : write byte          (captured with start)
//   busy   : frame in progress
//   done   : one-cycle pulse at frame end
//   rdata  : last byte read
// Modports:
//   master : the host issuing requests
//   slave  : the SPI frame engine serving them
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata
  );

endinterface

// File: rtl/spi_clk_div.sv
//-----------------------------------------------------------------------------
// spi_clk_div
// Half-period timebase for the SPI clock.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_en    : run enable; while low the counter and phase are held at zero
//   o_tick  : high for the last clk cycle of every CLK_DIV-cycle interval
//   o_phase : toggles on every tick; 0 during the first interval after enable
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_phase
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      // Restart cleanly so every frame sees the same tick alignment.
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_tick  = i_en && (r_cnt == LAST);
  assign o_phase = r_phase;

endmodule

// File: rtl/spi_master.sv
//-----------------------------------------------------------------------------
// spi_master
// Master-side SPI frame engine. One host request produces one 16-bit frame
// {addr, rw, data}, MSB first, preceded by a CS-high guard pulse on SCLK that
// returns the slave to its reset state. On reads the data field is sent as
// zero and the byte shifted in on MISO is returned on rdata.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (aborts any frame)
//   bus   : host request/response bus (spi_master_if.slave)
//   sclk  : SPI clock, idle low
//   cs    : chip select, active low, idle high
//   mosi  : master-out data, changes only while sclk is low
//   miso  : slave-out data, sampled as sclk rises
// Frame timing in units of D = CLK_DIV clk cycles:
//   GUARD 2D | SETUP D | XFER 32D | HOLD D | DONE 1 cycle
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  bus,
  output logic         sclk,
  output logic         cs,
  output logic         mosi,
  input  logic         miso
);

  localparam int            FW         = ADDR_W + 1 + DATA_W;
  localparam int            BW         = $clog2(FW);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FW - 1);
  localparam logic [BW-1:0] DATA_START = BW'(ADDR_W + 1);

  state_t            r_state;
  logic [FW-1:0]     r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rdata;
  logic [BW-1:0]     r_bitcnt;
  logic              r_rw;
  logic              r_last;     // last falling edge of the frame has occurred
  logic              r_sclk;
  logic              r_cs;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_phase;
  logic [DATA_W-1:0] w_wdata;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_busy),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  // A read sends a zero data field so the slave sees no stray write data.
  assign w_wdata = (bus.rw == RW_READ) ? '0 : bus.wdata;

  // Phase bookkeeping: the divider restarts at phase 0 when the frame is
  // accepted. GUARD uses two ticks, so SETUP and every SCLK-low interval of
  // XFER end on a phase-0 tick (rising edge) and every SCLK-high interval
  // ends on a phase-1 tick (falling edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_bitcnt <= '0;
      r_rw     <= 1'b0;
      r_last   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs     <= 1'b1;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_tx     <= {bus.addr, bus.rw, w_wdata};
            r_rw     <= bus.rw;
            r_bitcnt <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b1;
            r_sclk   <= 1'b1;          // guard pulse high half starts now
            r_state  <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (w_tick) begin
            if (!w_phase) begin
              r_sclk <= 1'b0;
            end else begin
              r_cs    <= 1'b0;
              r_mosi  <= r_tx[FW-1];
              r_state <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          // First rising edge carries an address bit, so nothing to sample.
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (w_tick) begin
            if (w_phase) begin
              // Falling edge: present the next bit.
              r_sclk <= 1'b0;
              r_tx   <= {r_tx[FW-2:0], 1'b0};
              r_mosi <= r_tx[FW-2];
              if (r_bitcnt == LAST_BIT) begin
                r_last <= 1'b1;        // bitcnt stays put; no wrap
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end else if (r_last) begin
              // Low half of the final bit period has elapsed.
              r_mosi  <= 1'b0;
              r_state <= ST_HOLD;
            end else begin
              // Rising edge: sample MISO during the data field of a read.
              r_sclk <= 1'b1;
              if (r_rw == RW_READ && r_bitcnt >= DATA_START) begin
                r_rx <= {r_rx[DATA_W-2:0], miso};
              end
            end
          end
        end

        ST_HOLD: begin
          if (w_tick) begin
            r_cs   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (r_rw == RW_READ) begin
              r_rdata <= r_rx;
            end
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk      = r_sclk;
  assign cs        = r_cs;
  assign mosi      = r_mosi;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;
  import spi_pkg::*;

  // Cycle n of a frame is the clock period ending with the n-th rising edge
  // after the edge that sampled start; outputs are sampled on falling edges.

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.ADDR_W(7), .DATA_W(8)) bus_a ();
  spi_master_if #(.ADDR_W(7), .DATA_W(8)) bus_b ();

  logic sclk_a, cs_a, mosi_a, miso_a;
  logic sclk_b, cs_b, mosi_b, miso_b;

  spi_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CLK_DIV(2), .ADDR_W(7), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
    .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave byte is driven on frame bits 8..15, zero on the address bits.
  function automatic logic sbit(input logic [7:0] b, input int idx);
    return (idx >= 8 && idx <= 15) ? b[15-idx] : 1'b0;
  endfunction

  // ---------------- monitors / slave model, instance A ----------------
  logic [15:0] cap_a = '0;
  int rises_a = 0, guard_a = 0, frames_a = 0, dones_a = 0, cslow_a = 0;
  logic [7:0] sbyte_a = '0;
  int sidx_a = 0;
  initial miso_a = 1'b0;

  always @(posedge sclk_a) begin
    if (cs_a === 1'b0) begin cap_a = {cap_a[14:0], mosi_a}; rises_a++; end
    else guard_a++;
  end
  always @(negedge cs_a) begin
    frames_a++; sidx_a = 0; miso_a = sbit(sbyte_a, 0);
  end
  always @(negedge sclk_a) begin
    if (cs_a === 1'b0) begin sidx_a++; miso_a = sbit(sbyte_a, sidx_a); end
  end
  always @(negedge clk) begin
    if (bus_a.done === 1'b1) dones_a++;
    if (cs_a === 1'b0) cslow_a++;
  end

  // ---------------- monitors / slave model, instance B ----------------
  logic [15:0] cap_b = '0;
  logic [7:0] sbyte_b = '0;
  int sidx_b = 0;
  initial miso_b = 1'b0;

  always @(posedge sclk_b) begin
    if (cs_b === 1'b0) cap_b = {cap_b[14:0], mosi_b};
  end
  always @(negedge cs_b) begin
    sidx_b = 0; miso_b = sbit(sbyte_b, 0);
  end
  always @(negedge sclk_b) begin
    if (cs_b === 1'b0) begin sidx_b++; miso_b = sbit(sbyte_b, sidx_b); end
  end

  // ---------------- host drivers ----------------
  task automatic start_a(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    cap_a = '0; rises_a = 0; guard_a = 0; frames_a = 0; dones_a = 0; cslow_a = 0;
    bus_a.addr = a; bus_a.rw = r; bus_a.wdata = d; bus_a.start = 1'b1;
    @(posedge clk); #1;
    // Inputs may change freely once accepted.
    bus_a.start = 1'b0; bus_a.addr = ~a; bus_a.rw = ~r; bus_a.wdata = ~d;
  endtask

  task automatic start_b(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    cap_b = '0;
    bus_b.addr = a; bus_b.rw = r; bus_b.wdata = d; bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0; bus_b.addr = ~a; bus_b.rw = ~r; bus_b.wdata = ~d;
  endtask

  task automatic wait_done_a(output int cyc, output logic busy1);
    cyc = -1; busy1 = 1'bx;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = bus_a.busy;
      if (bus_a.done === 1'b1) begin cyc = n; break; end
    end
  endtask

  task automatic wait_done_b(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (bus_b.done === 1'b1) begin cyc = n; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_a, sclk_a, mosi_a, bus_a.busy, bus_a.done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_pins: got cs,sclk,mosi,busy,done=%b required 10000",
               {cs_a, sclk_a, mosi_a, bus_a.busy, bus_a.done});
    end
    n_checks++;
    if (bus_a.rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h required 00", bus_a.rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_read();
    int cyc; logic b1;
    sbyte_a = 8'hA5;
    start_a(7'h05, 1'b1, 8'h77);
    wait_done_a(cyc, b1);
    $display("read A addr=05 rdata=%h done cycle=%0d", bus_a.rdata, cyc);
    n_checks++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b required 1", b1); end
    n_checks++;
    if (cyc !== 145) begin n_fail++; $display("FAIL read_latency: got %0d required 145", cyc); end
    n_checks++;
    if (bus_a.busy !== 1'b0 || cs_a !== 1'b1) begin
      n_fail++; $display("FAIL read_done_pins: got busy=%b cs=%b required 0 1", bus_a.busy, cs_a);
    end
    @(negedge clk);
    n_checks++;
    if (cap_a !== 16'h0B00) begin n_fail++; $display("FAIL read_mosi: got %h required 0b00", cap_a); end
    n_checks++;
    if (bus_a.rdata !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h required a5", bus_a.rdata); end
    n_checks++;
    if (dones_a !== 1) begin n_fail++; $display("FAIL read_done_count: got %0d required 1", dones_a); end
    n_checks++;
    if (guard_a !== 1 || rises_a !== 16) begin
      n_fail++; $display("FAIL read_sclk_count: got guard=%0d rises=%0d required 1 16", guard_a, rises_a);
    end
  endtask

  task automatic test_write();
    int cyc; logic b1;
    sbyte_a = 8'h3C;
    start_a(7'h2A, 1'b0, 8'hC3);
    wait_done_a(cyc, b1);
    $display("write A addr=2a wdata=c3 done cycle=%0d", cyc);
    n_checks++;
    if (cyc !== 145) begin n_fail++; $display("FAIL write_latency: got %0d required 145", cyc); end
    n_checks++;
    if (mosi_a !== 1'b0 || sclk_a !== 1'b0) begin
      n_fail++; $display("FAIL write_done_pins: got mosi=%b sclk=%b required 0 0", mosi_a, sclk_a);
    end
    @(negedge clk);
    n_checks++;
    if (cap_a !== 16'h54C3) begin n_fail++; $display("FAIL write_mosi: got %h required 54c3", cap_a); end
    n_checks++;
    if (cslow_a !== 136) begin n_fail++; $display("FAIL write_cs_low: got %0d required 136", cslow_a); end
    n_checks++;
    if (bus_a.rdata !== 8'hA5) begin n_fail++; $display("FAIL write_rdata_kept: got %h required a5", bus_a.rdata); end
  endtask

  task automatic test_ignore_start();
    int cyc;
    start_a(7'h12, 1'b0, 8'h0F);
    cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      bus_a.start = (n == 10 || n == 100);
      if (n == 10 || n == 100) begin bus_a.addr = 7'h7F; bus_a.rw = 1'b1; bus_a.wdata = 8'hFF; end
      if (bus_a.done === 1'b1) begin
        cyc = n;
        bus_a.start = 1'b1;           // request during DONE must also be dropped
        break;
      end
    end
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (40) @(negedge clk);
    $display("ignore A addr=12 done cycle=%0d frames=%0d", cyc, frames_a);
    n_checks++;
    if (cyc !== 145) begin n_fail++; $display("FAIL ignore_latency: got %0d required 145", cyc); end
    n_checks++;
    if (frames_a !== 1 || dones_a !== 1) begin
      n_fail++; $display("FAIL ignore_counts: got frames=%0d dones=%0d required 1 1", frames_a, dones_a);
    end
    n_checks++;
    if (cap_a !== 16'h240F) begin n_fail++; $display("FAIL ignore_mosi: got %h required 240f", cap_a); end
    n_checks++;
    if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b required 0", bus_a.busy); end
  endtask

  task automatic test_abort();
    int cyc; logic b1;
    sbyte_a = 8'h3C;
    start_a(7'h33, 1'b1, 8'h00);
    repeat (60) @(negedge clk);
    n_checks++;
    if (cs_a !== 1'b0) begin n_fail++; $display("FAIL abort_midframe_cs: got %b required 0", cs_a); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cs_a !== 1'b1 || sclk_a !== 1'b0 || bus_a.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_pins: got cs=%b sclk=%b busy=%b required 1 0 0", cs_a, sclk_a, bus_a.busy);
    end
    n_checks++;
    if (bus_a.rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rdata: got %h required 00", bus_a.rdata); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++;
    if (dones_a !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", dones_a); end
    $display("abort A at cycle 60, rdata=%h", bus_a.rdata);
    start_a(7'h2A, 1'b0, 8'hC3);
    wait_done_a(cyc, b1);
    @(negedge clk);
    $display("write A after abort done cycle=%0d", cyc);
    n_checks++;
    if (cyc !== 145 || cap_a !== 16'h54C3) begin
      n_fail++; $display("FAIL abort_recover: got cycle=%0d mosi=%h required 145 54c3", cyc, cap_a);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; logic b1; logic [15:0] cap1;
    sbyte_a = 8'h81;
    start_a(7'h11, 1'b0, 8'h5A);
    wait_done_a(cyc1, b1);
    start_a(7'h11, 1'b1, 8'h00);     // first negedge is the cycle after done
    cap1 = 16'h0;
    wait_done_a(cyc2, b1);
    @(negedge clk);
    $display("b2b A write cycle=%0d read cycle=%0d rdata=%h", cyc1, cyc2, bus_a.rdata);
    n_checks++;
    if (cyc1 !== 145 || cyc2 !== 145) begin
      n_fail++; $display("FAIL b2b_latency: got %0d %0d required 145 145", cyc1, cyc2);
    end
    n_checks++;
    if (guard_a !== 1 || frames_a !== 1 || dones_a !== 1) begin
      n_fail++; $display("FAIL b2b_guard: got guard=%0d frames=%0d dones=%0d required 1 1 1",
                         guard_a, frames_a, dones_a);
    end
    n_checks++;
    if (cap_a !== 16'h2300 || bus_a.rdata !== 8'h81) begin
      n_fail++; $display("FAIL b2b_read: got mosi=%h rdata=%h required 2300 81", cap_a, bus_a.rdata);
    end
    cap1 = cap_a;
  endtask

  task automatic test_div2();
    int cyc;
    sbyte_b = 8'hFF;
    start_b(7'h40, 1'b1, 8'h12);
    wait_done_b(cyc);
    @(negedge clk);
    $display("read B addr=40 rdata=%h done cycle=%0d", bus_b.rdata, cyc);
    n_checks++;
    if (cyc !== 73) begin n_fail++; $display("FAIL div2_latency1: got %0d required 73", cyc); end
    n_checks++;
    if (bus_b.rdata !== 8'hFF || cap_b !== 16'h8100) begin
      n_fail++; $display("FAIL div2_read1: got rdata=%h mosi=%h required ff 8100", bus_b.rdata, cap_b);
    end
    sbyte_b = 8'h00;
    start_b(7'h01, 1'b1, 8'hEE);
    wait_done_b(cyc);
    @(negedge clk);
    $display("read B addr=01 rdata=%h done cycle=%0d", bus_b.rdata, cyc);
    n_checks++;
    if (cyc !== 73) begin n_fail++; $display("FAIL div2_latency2: got %0d required 73", cyc); end
    n_checks++;
    if (bus_b.rdata !== 8'h00 || cap_b !== 16'h0300) begin
      n_fail++; $display("FAIL div2_read2: got rdata=%h mosi=%h required 00 0300", bus_b.rdata, cap_b);
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.rw = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.start = 1'b0; bus_b.rw = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    test_reset();
    test_read();
    test_write();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_div2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
